// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates ROB ids, collects write-backs, commits to the CDB.
// Optional ROB_WB_FORWARD_EN: queries also see same-cycle rs/lsb write-backs.
module reorder_buffer #(
    parameter int ROB_INDEX_BIT = 4,
    parameter int ROB_CAP       = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     inst_req,
    input  logic [1:0]               inst_kind,
    input  logic [4:0]               inst_rd,
    input  logic                     inst_pred_taken,
    input  logic [31:0]              inst_alt_addr,
    output logic [ROB_INDEX_BIT-1:0] alloc_rob_id,
    output logic                     full,

    input  logic                     rs_ready,
    input  logic [ROB_INDEX_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_result,
    input  logic                     lsb_ready,
    input  logic [ROB_INDEX_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_result,

    input  logic [ROB_INDEX_BIT-1:0] q1_id,
    input  logic [ROB_INDEX_BIT-1:0] q2_id,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [31:0]              q1_val,
    output logic [31:0]              q2_val,

    output logic                     cdb_req,
    output logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
    output logic [31:0]              cdb_val,
    output logic [4:0]               cdb_rd,

    output logic                     store_commit,
    output logic [ROB_INDEX_BIT-1:0] store_commit_rob_id,

    output logic                     clear,
    output logic [31:0]              clear_pc
);

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_JALR   = 2'd3
    } kind_e;

    localparam int CW = ROB_INDEX_BIT + 1;
    localparam logic [ROB_INDEX_BIT-1:0] IDX_ONE   = ROB_INDEX_BIT'(1);
    localparam logic [CW-1:0]            CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]            CAP_CNT   = CW'(ROB_CAP);
    localparam logic [CW-1:0]            FULL_MARK = CW'(ROB_CAP - 2);

    logic [ROB_INDEX_BIT-1:0] head_q;
    logic [ROB_INDEX_BIT-1:0] tail_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;

    logic [ROB_CAP-1:0] busy_q;
    logic [ROB_CAP-1:0] ready_q;
    kind_e              kind_q  [ROB_CAP];
    logic [4:0]         rd_q    [ROB_CAP];
    logic               pred_q  [ROB_CAP];
    logic [31:0]        alt_q   [ROB_CAP];
    logic [31:0]        value_q [ROB_CAP];

    kind_e       head_kind;
    logic [4:0]  head_rd;
    logic        head_pred;
    logic [31:0] head_alt;
    logic [31:0] head_value;

    logic accept_gate;
    logic rs_ok;
    logic lsb_ok;
    logic do_alloc;
    logic do_commit;
    logic mispredict;
    logic flush;

    assign head_kind  = kind_q[head_q];
    assign head_rd    = rd_q[head_q];
    assign head_pred  = pred_q[head_q];
    assign head_alt   = alt_q[head_q];
    assign head_value = value_q[head_q];

    assign alloc_rob_id = tail_q;

    // The cycle after a redirect belongs to the flushed path, so inputs are dropped.
    assign accept_gate = rdy_in && !clear;
    assign rs_ok       = accept_gate && rs_ready && busy_q[rs_rob_id];
    assign lsb_ok      = accept_gate && lsb_ready && busy_q[lsb_rob_id];

    assign do_commit  = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign mispredict = (head_kind == KIND_BRANCH)
                     && (head_value[0] != head_pred);
    assign flush      = do_commit
                     && ((head_kind == KIND_JALR) || mispredict);

    assign do_alloc = accept_gate && inst_req
                   && ((count_q != CAP_CNT) || do_commit);

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_alloc && !do_commit) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_alloc && do_commit) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        q1_ready = busy_q[q1_id] && ready_q[q1_id];
        q1_val   = value_q[q1_id];
        q2_ready = busy_q[q2_id] && ready_q[q2_id];
        q2_val   = value_q[q2_id];
`ifdef ROB_WB_FORWARD_EN
        if (rs_ok && (rs_rob_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_val   = rs_result;
        end
        if (lsb_ok && (lsb_rob_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_val   = lsb_result;
        end
        if (rs_ok && (rs_rob_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_val   = rs_result;
        end
        if (lsb_ok && (lsb_rob_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_val   = lsb_result;
        end
`endif
    end

    // Control state and registered commit outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            busy_q              <= '0;
            ready_q             <= '0;
            full                <= 1'b0;
            cdb_req             <= 1'b0;
            cdb_rob_id          <= '0;
            cdb_val             <= '0;
            cdb_rd              <= '0;
            store_commit        <= 1'b0;
            store_commit_rob_id <= '0;
            clear               <= 1'b0;
            clear_pc            <= '0;
        end else if (rdy_in) begin
            cdb_req      <= 1'b0;
            store_commit <= 1'b0;
            clear        <= 1'b0;

            if (rs_ok) begin
                ready_q[rs_rob_id] <= 1'b1;
            end
            if (lsb_ok) begin
                ready_q[lsb_rob_id] <= 1'b1;
            end

            if (do_commit) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + IDX_ONE;
                unique case (1'b1)
                    (head_kind == KIND_REG): begin
                        cdb_req    <= 1'b1;
                        cdb_rob_id <= head_q;
                        cdb_val    <= head_value;
                        cdb_rd     <= head_rd;
                    end
                    (head_kind == KIND_JALR): begin
                        cdb_req    <= 1'b1;
                        cdb_rob_id <= head_q;
                        cdb_val    <= head_alt;
                        cdb_rd     <= head_rd;
                        clear      <= 1'b1;
                        clear_pc   <= {head_value[31:1], 1'b0};
                    end
                    (head_kind == KIND_BRANCH): begin
                        if (mispredict) begin
                            clear    <= 1'b1;
                            clear_pc <= head_alt;
                        end
                    end
                    (head_kind == KIND_STORE): begin
                        store_commit        <= 1'b1;
                        store_commit_rob_id <= head_q;
                    end
                endcase
            end

            // A full buffer may reuse the slot being committed this cycle.
            if (do_alloc) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= tail_q + IDX_ONE;
            end

            if (flush) begin
                busy_q  <= '0;
                ready_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
            end

            count_q <= count_d;
            full    <= (count_d >= FULL_MARK);
        end
    end

    // Entry payload needs no reset; busy/ready qualify it.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (rs_ok) begin
                value_q[rs_rob_id] <= rs_result;
            end
            if (lsb_ok) begin
                value_q[lsb_rob_id] <= lsb_result;
            end
            if (do_alloc) begin
                kind_q[tail_q] <= kind_e'(inst_kind);
                rd_q[tail_q]   <= inst_rd;
                pred_q[tail_q] <= inst_pred_taken;
                alt_q[tail_q]  <= inst_alt_addr;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-level reference model.
// The model is checked every cycle; literal checks pin key scenarios.
module tb_reorder_buffer;

    localparam int IB  = 4;
    localparam int CAP = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          inst_req;
    logic [1:0]    inst_kind;
    logic [4:0]    inst_rd;
    logic          inst_pred_taken;
    logic [31:0]   inst_alt_addr;
    logic [IB-1:0] alloc_rob_id;
    logic          full;
    logic          rs_ready;
    logic [IB-1:0] rs_rob_id;
    logic [31:0]   rs_result;
    logic          lsb_ready;
    logic [IB-1:0] lsb_rob_id;
    logic [31:0]   lsb_result;
    logic [IB-1:0] q1_id;
    logic [IB-1:0] q2_id;
    logic          q1_ready;
    logic          q2_ready;
    logic [31:0]   q1_val;
    logic [31:0]   q2_val;
    logic          cdb_req;
    logic [IB-1:0] cdb_rob_id;
    logic [31:0]   cdb_val;
    logic [4:0]    cdb_rd;
    logic          store_commit;
    logic [IB-1:0] store_commit_rob_id;
    logic          clear;
    logic [31:0]   clear_pc;

    reorder_buffer #(.ROB_INDEX_BIT(IB), .ROB_CAP(CAP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .inst_req(inst_req), .inst_kind(inst_kind), .inst_rd(inst_rd),
        .inst_pred_taken(inst_pred_taken), .inst_alt_addr(inst_alt_addr),
        .alloc_rob_id(alloc_rob_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_result(rs_result),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_result(lsb_result),
        .q1_id(q1_id), .q2_id(q2_id),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .cdb_req(cdb_req), .cdb_rob_id(cdb_rob_id),
        .cdb_val(cdb_val), .cdb_rd(cdb_rd),
        .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id),
        .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        int          kind;
        int          rd;
        bit          pred;
        logic [31:0] alt;
        logic [31:0] val;
        bit          rdy;
    } ent_t;

    ent_t        rob[$];
    int          m_tail;
    bit          m_live = 0;
    bit          e_cdb_req, e_st, e_clear, e_full;
    int          e_cdb_id, e_rd, e_st_id;
    logic [31:0] e_cdb_val, e_clear_pc;
    bit          was_clear, flush;
    ent_t        h;

    task automatic model_wb(input int id, input logic [31:0] v);
        foreach (rob[i]) begin
            if (rob[i].id == id) begin
                rob[i].val = v;
                rob[i].rdy = 1'b1;
            end
        end
    endtask

    function automatic int model_find(input int id);
        foreach (rob[i]) begin
            if (rob[i].id == id) return i;
        end
        return -1;
    endfunction

    task automatic check_query(input string nm, input logic [IB-1:0] qid,
                               input logic rdy, input logic [31:0] val);
        int  k;
        bit  er;
        k  = model_find(int'(qid));
        er = (k >= 0) && rob[k].rdy;
        chk({nm, "_ready"}, {31'd0, rdy}, {31'd0, er});
        if (er) chk({nm, "_val"}, val, rob[k].val);
    endtask

    // Reference model: in-order queue; outputs derived from commit rules.
    always @(posedge clk_in) begin
        if (rst_in) begin
            rob.delete();
            m_tail     = 0;
            m_live     = 1;
            e_cdb_req  = 0; e_cdb_id = 0; e_cdb_val = 0; e_rd = 0;
            e_st       = 0; e_st_id = 0;
            e_clear    = 0; e_clear_pc = 0;
            e_full     = 0;
        end else if (rdy_in && m_live) begin
            was_clear = e_clear;
            flush     = 0;
            e_cdb_req = 0;
            e_st      = 0;
            e_clear   = 0;
            if (rob.size() > 0 && rob[0].rdy) begin
                h = rob.pop_front();
                case (h.kind)
                    0: begin
                        e_cdb_req = 1; e_cdb_id = h.id;
                        e_cdb_val = h.val; e_rd = h.rd;
                    end
                    1: if (h.val[0] != h.pred) begin
                        e_clear = 1; e_clear_pc = h.alt; flush = 1;
                    end
                    2: begin
                        e_st = 1; e_st_id = h.id;
                    end
                    default: begin
                        e_cdb_req = 1; e_cdb_id = h.id;
                        e_cdb_val = h.alt; e_rd = h.rd;
                        e_clear = 1; e_clear_pc = h.val & 32'hffff_fffe;
                        flush = 1;
                    end
                endcase
            end
            if (!was_clear) begin
                if (rs_ready)  model_wb(int'(rs_rob_id), rs_result);
                if (lsb_ready) model_wb(int'(lsb_rob_id), lsb_result);
                if (inst_req && rob.size() < CAP) begin
                    h.id   = m_tail;
                    h.kind = int'(inst_kind);
                    h.rd   = int'(inst_rd);
                    h.pred = inst_pred_taken;
                    h.alt  = inst_alt_addr;
                    h.val  = 0;
                    h.rdy  = 0;
                    rob.push_back(h);
                    m_tail = (m_tail + 1) % CAP;
                end
            end
            if (flush) begin
                rob.delete();
                m_tail = 0;
            end
            e_full = rob.size() >= CAP - 2;
        end
        #1;
        if (m_live) begin
            chk("m_cdb_req", {31'd0, cdb_req}, {31'd0, e_cdb_req});
            if (e_cdb_req) begin
                chk("m_cdb_id", 32'(cdb_rob_id), e_cdb_id);
                chk("m_cdb_val", cdb_val, e_cdb_val);
                chk("m_cdb_rd", 32'(cdb_rd), e_rd);
            end
            chk("m_store", {31'd0, store_commit}, {31'd0, e_st});
            if (e_st) chk("m_store_id", 32'(store_commit_rob_id), e_st_id);
            chk("m_clear", {31'd0, clear}, {31'd0, e_clear});
            if (e_clear) chk("m_clear_pc", clear_pc, e_clear_pc);
            chk("m_full", {31'd0, full}, {31'd0, e_full});
            chk("m_alloc_id", 32'(alloc_rob_id), m_tail);
            check_query("m_q1", q1_id, q1_ready, q1_val);
            check_query("m_q2", q2_id, q2_ready, q2_val);
        end
    end

    task automatic alloc(input int kind, input int rd, input bit pred,
                         input logic [31:0] alt);
        inst_req        = 1'b1;
        inst_kind       = 2'(kind);
        inst_rd         = 5'(rd);
        inst_pred_taken = pred;
        inst_alt_addr   = alt;
        @(negedge clk_in);
        inst_req = 1'b0;
    endtask

    task automatic rs_wb(input int id, input logic [31:0] v);
        rs_ready  = 1'b1;
        rs_rob_id = IB'(id);
        rs_result = v;
        @(negedge clk_in);
        rs_ready = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        inst_req = 1'b0; inst_kind = '0; inst_rd = '0;
        inst_pred_taken = 1'b0; inst_alt_addr = '0;
        rs_ready = 1'b0; rs_rob_id = '0; rs_result = '0;
        lsb_ready = 1'b0; lsb_rob_id = '0; lsb_result = '0;
        q1_id = '0; q2_id = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_cdb_req", {31'd0, cdb_req}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_alloc_id", 32'(alloc_rob_id), 0);
        chk("rst_clear", {31'd0, clear}, 0);
        chk("rst_store", {31'd0, store_commit}, 0);
        rst_in = 1'b0;

        // Out-of-order write-back, in-order commit.
        alloc(0, 1, 0, 0);
        alloc(0, 2, 0, 0);
        alloc(0, 3, 0, 0);
        chk("alloc_id3", 32'(alloc_rob_id), 3);
        rs_wb(2, 7);
        rs_wb(0, 5);
        chk("no_commit_yet", {31'd0, cdb_req}, 0);
        rs_ready = 1'b1; rs_rob_id = 4'd1; rs_result = 6;
        @(negedge clk_in);
        rs_ready = 1'b0;
        chk("c0_req", {31'd0, cdb_req}, 1);
        chk("c0_id", 32'(cdb_rob_id), 0);
        chk("c0_val", cdb_val, 5);
        @(negedge clk_in);
        chk("c1_id", 32'(cdb_rob_id), 1);
        chk("c1_val", cdb_val, 6);
        @(negedge clk_in);
        chk("c2_id", 32'(cdb_rob_id), 2);
        chk("c2_val", cdb_val, 7);
        chk("c2_rd", 32'(cdb_rd), 3);
        @(negedge clk_in);
        chk("c_idle", {31'd0, cdb_req}, 0);

        // Mispredicted branch and ignored issue during clear.
        alloc(1, 0, 1, 32'h100);
        rs_wb(3, 0);
        @(negedge clk_in);
        chk("br_clear", {31'd0, clear}, 1);
        chk("br_pc", clear_pc, 32'h100);
        chk("br_no_cdb", {31'd0, cdb_req}, 0);
        chk("br_alloc_id", 32'(alloc_rob_id), 0);
        inst_req = 1'b1; inst_kind = 2'd0; inst_rd = 5'd9;
        @(negedge clk_in);
        inst_req = 1'b0;
        chk("br_ign_alloc", 32'(alloc_rob_id), 0);
        chk("br_pulse", {31'd0, clear}, 0);

        // Fill to the full mark, commit one, then wrap the tail.
        for (int i = 0; i < 14; i++) begin
            alloc(0, i, 0, 0);
            if (i == 12) chk("full_13", {31'd0, full}, 0);
        end
        chk("full_14", {31'd0, full}, 1);
        rs_wb(0, 32'h50);
        @(negedge clk_in);
        chk("rd0_req", {31'd0, cdb_req}, 1);
        chk("rd0_rd", 32'(cdb_rd), 0);
        chk("rd0_val", cdb_val, 32'h50);
        chk("full_drop", {31'd0, full}, 0);
        alloc(0, 14, 0, 0);
        alloc(0, 15, 0, 0);
        chk("wrap_id", 32'(alloc_rob_id), 0);
        alloc(0, 20, 0, 0);
        chk("wrap_next", 32'(alloc_rob_id), 1);
        for (int k = 1; k < 16; k++) rs_wb(k, 32'h100 + k);
        rs_wb(0, 32'h1ff);
        repeat (20) @(negedge clk_in);
        chk("drain_full", {31'd0, full}, 0);
        chk("drain_tail", 32'(alloc_rob_id), 1);

        // JALR: link on CDB, redirect to target with bit 0 cleared.
        alloc(3, 5, 0, 32'h24);
        rs_wb(1, 32'h1003);
        @(negedge clk_in);
        chk("jalr_req", {31'd0, cdb_req}, 1);
        chk("jalr_val", cdb_val, 32'h24);
        chk("jalr_rd", 32'(cdb_rd), 5);
        chk("jalr_clear", {31'd0, clear}, 1);
        chk("jalr_pc", clear_pc, 32'h1002);
        @(negedge clk_in);

        // Store commit, then stall with rdy_in low.
        alloc(2, 0, 0, 0);
        lsb_ready = 1'b1; lsb_rob_id = 4'd0; lsb_result = 0;
        @(negedge clk_in);
        lsb_ready = 1'b0;
        @(negedge clk_in);
        chk("st_commit", {31'd0, store_commit}, 1);
        chk("st_id", 32'(store_commit_rob_id), 0);
        chk("st_no_cdb", {31'd0, cdb_req}, 0);
        rdy_in = 1'b0;
        inst_req = 1'b1; inst_kind = 2'd0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_in);
            chk("hold_st", {31'd0, store_commit}, 1);
            chk("hold_alloc", 32'(alloc_rob_id), 1);
        end
        rdy_in = 1'b1;
        inst_req = 1'b0;
        @(negedge clk_in);
        chk("st_pulse_end", {31'd0, store_commit}, 0);

        // Query timing around a write-back, with dual write-back.
        alloc(0, 7, 0, 0);
        alloc(0, 8, 0, 0);
        alloc(0, 9, 0, 0);
        q1_id = 4'd3; q2_id = 4'd2;
        rs_ready = 1'b1; rs_rob_id = 4'd3; rs_result = 9;
        lsb_ready = 1'b1; lsb_rob_id = 4'd2; lsb_result = 8;
        #1;
`ifdef ROB_WB_FORWARD_EN
        chk("q1_fwd_ready", {31'd0, q1_ready}, 1);
        chk("q1_fwd_val", q1_val, 9);
`else
        chk("q1_pre_ready", {31'd0, q1_ready}, 0);
`endif
        @(negedge clk_in);
        rs_ready = 1'b0; lsb_ready = 1'b0;
        chk("q1_ready", {31'd0, q1_ready}, 1);
        chk("q1_val", q1_val, 9);
        chk("q2_ready", {31'd0, q2_ready}, 1);
        chk("q2_val", q2_val, 8);
        rs_wb(1, 6);
        repeat (6) @(negedge clk_in);
        chk("end_tail", 32'(alloc_rob_id), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
